// File: rtl/clint.sv
// -----------------------------------------------------------------------------
// clint -- core-local interruptor for the npc core.
//
// Holds the free-running 64-bit machine timer (mtime), its compare register
// (mtimecmp) and the machine software-interrupt bit (msip). These registers are
// memory mapped behind a simple valid/ready request/response port driven by
// the LSU. The block produces the MTIP and MSIP pending bits that the CSR file
// exposes in mip.
//
// Register map (byte offsets from BASE, 8-byte aligned):
//   0x0000  msip      bit 0 R/W, bits 63:1 read as zero, writes ignored
//   0x4000  mtimecmp  64-bit R/W
//   0xBFF8  mtime     64-bit R/W
// Any other address (including misaligned ones) completes with resp_err=1,
// resp_rdata=0 and leaves all state untouched.
//
// Parameters:
//   XLEN      bus/register width (only 64 is supported)
//   BASE      byte address of the register block
//   TICK_DIV  core clocks per mtime increment (1..65535)
//
// Ports:
//   clk          core clock
//   rst          synchronous, active-high reset
//   req_valid    request present
//   req_ready    block can accept a request (high only in IDLE)
//   req_wen      1 = write, 0 = read
//   req_addr     byte address
//   req_wdata    write data
//   req_wmask    byte enables, bit i covers wdata[8i+7:8i]
//   resp_valid   response present (high only in RESP)
//   resp_ready   consumer takes the response
//   resp_rdata   read data (0 for writes and errors)
//   resp_err     access fault
//   mtip_o       machine timer interrupt pending (to mip.MTIP)
//   msip_o       machine software interrupt pending (to mip.MSIP)
// -----------------------------------------------------------------------------
module clint #(
  parameter int unsigned          XLEN     = 64,
  parameter logic [XLEN-1:0]      BASE     = 'h0200_0000,
  parameter int unsigned          TICK_DIV = 1
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [7:0]      req_wmask,

  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,

  output logic            mtip_o,
  output logic            msip_o
);

  // ---------------------------------------------------------------------------
  // Address map and prescaler constants
  // ---------------------------------------------------------------------------
  localparam logic [XLEN-1:0] ADDR_MSIP     = BASE;
  localparam logic [XLEN-1:0] ADDR_MTIMECMP = BASE + XLEN'(32'h0000_4000);
  localparam logic [XLEN-1:0] ADDR_MTIME    = BASE + XLEN'(32'h0000_BFF8);

  // Last value of the prescaler; with TICK_DIV=1 this is 0 and every cycle
  // is a tick.
  localparam logic [15:0]     DIV_LAST      = 16'(TICK_DIV - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q,    state_d;
  logic [XLEN-1:0]   mtime_q,    mtime_d;
  logic [XLEN-1:0]   mtimecmp_q, mtimecmp_d;
  logic              msip_q,     msip_d;
  logic [15:0]       div_cnt_q,  div_cnt_d;
  logic              mtip_q,     mtip_d;
  logic [XLEN-1:0]   rdata_q,    rdata_d;
  logic              err_q,      err_d;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic            accept;
  logic            hit_msip;
  logic            hit_mtimecmp;
  logic            hit_mtime;
  logic            addr_err;
  logic            wr_msip;
  logic            wr_mtimecmp;
  logic            wr_mtime;
  logic            tick;
  logic [XLEN-1:0] bit_mask;
  logic [XLEN-1:0] read_mux;

  // A request is only taken in IDLE; the RESP state blocks new requests,
  // including in the cycle the response is consumed.
  assign accept       = req_valid && (state_q == ST_IDLE);

  // Full-width compares: the aligned register addresses are the only legal
  // ones, so the explicit alignment check below only documents intent.
  assign hit_msip     = (req_addr == ADDR_MSIP);
  assign hit_mtimecmp = (req_addr == ADDR_MTIMECMP);
  assign hit_mtime    = (req_addr == ADDR_MTIME);
  assign addr_err     = (req_addr[2:0] != 3'b000) ||
                        !(hit_msip || hit_mtimecmp || hit_mtime);

  assign wr_msip      = accept && req_wen && !addr_err && hit_msip;
  assign wr_mtimecmp  = accept && req_wen && !addr_err && hit_mtimecmp;
  // A zero byte mask is a pure no-op, so it must not swallow a tick that
  // happens to land in the same cycle.
  assign wr_mtime     = accept && req_wen && !addr_err && hit_mtime &&
                        (req_wmask != 8'h00);

  assign tick         = (div_cnt_q == DIV_LAST);

  // Expand the byte enables into a per-bit mask.
  for (genvar gi = 0; gi < 8; gi++) begin : g_mask
    assign bit_mask[8*gi +: 8] = {8{req_wmask[gi]}};
  end

  // Read data is taken from the register values held in the accept cycle,
  // i.e. before any increment that happens at the end of that cycle.
  always_comb begin
    read_mux = '0;
    if (hit_msip) begin
      read_mux = {{(XLEN-1){1'b0}}, msip_q};
    end else if (hit_mtimecmp) begin
      read_mux = mtimecmp_q;
    end else if (hit_mtime) begin
      read_mux = mtime_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    div_cnt_d  = div_cnt_q;
    mtip_d     = mtip_q;
    rdata_d    = rdata_q;
    err_d      = err_q;

    // Prescaler and timer run regardless of the bus FSM state.
    if (tick) begin
      div_cnt_d = '0;
      mtime_d   = mtime_q + XLEN'(1);
    end else begin
      div_cnt_d = div_cnt_q + 16'd1;
    end

    // Software write to mtime beats a simultaneous tick: unmasked bytes keep
    // the un-incremented value. The prescaler phase is left alone.
    if (wr_mtime) begin
      mtime_d = (mtime_q & ~bit_mask) | (req_wdata & bit_mask);
    end

    if (wr_mtimecmp) begin
      mtimecmp_d = (mtimecmp_q & ~bit_mask) | (req_wdata & bit_mask);
    end

    if (wr_msip && req_wmask[0]) begin
      msip_d = req_wdata[0];
    end

    // Compare uses the values held this cycle, so a register write reaches
    // mtip one cycle after it lands in the register.
    mtip_d = (mtime_q >= mtimecmp_q);

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RESP;
          err_d   = addr_err;
          rdata_d = (!req_wen && !addr_err) ? read_mux : '0;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      div_cnt_q  <= '0;
      mtip_q     <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      div_cnt_q  <= div_cnt_d;
      mtip_q     <= mtip_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all straight from flops (handshake flags decode the state flop)
  // ---------------------------------------------------------------------------
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mtip_o     = mtip_q;
  assign msip_o     = msip_q;

endmodule

// File: tb/tb_clint.sv
// -----------------------------------------------------------------------------
// tb_clint -- self-checking bench for clint.
//
// Two instances share one request bus: dut1 runs with TICK_DIV=1 and dut4 with
// TICK_DIV=4; 'sel' steers req_valid to one of them and muxes the response
// back. Each issued transaction pushes its expected response into a queue; a
// monitor pops and compares whenever a response is handed over. 'cnt' counts
// clock cycles since reset release, so the expected mtime at any accept cycle
// is derived from it. Pin-level checks (mtip/msip, stall behaviour) are made
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_clint;

  localparam logic [63:0] BASE   = 64'h0200_0000;
  localparam logic [63:0] A_MSIP = BASE;
  localparam logic [63:0] A_CMP  = BASE + 64'h4000;
  localparam logic [63:0] A_TIME = BASE + 64'hBFF8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic        req_valid;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_ready;

  logic        req_valid_a, req_valid_b;
  logic        req_ready_a, req_ready_b;
  logic        resp_valid_a, resp_valid_b;
  logic [63:0] resp_rdata_a, resp_rdata_b;
  logic        resp_err_a, resp_err_b;
  logic        mtip_a, mtip_b, msip_a, msip_b;

  assign req_valid_a = req_valid && !sel;
  assign req_valid_b = req_valid &&  sel;

  clint #(.XLEN(64), .BASE(BASE), .TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid_a), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata_a), .resp_err(resp_err_a),
    .mtip_o(mtip_a), .msip_o(msip_a)
  );

  clint #(.XLEN(64), .BASE(BASE), .TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata_b), .resp_err(resp_err_b),
    .mtip_o(mtip_b), .msip_o(msip_b)
  );

  logic        m_valid, m_err;
  logic [63:0] m_rdata;
  assign m_valid = sel ? resp_valid_b : resp_valid_a;
  assign m_rdata = sel ? resp_rdata_b : resp_rdata_a;
  assign m_err   = sel ? resp_err_b   : resp_err_a;

  // Cycles elapsed since reset release (cycle 0 = first cycle with rst low).
  int cnt;
  always @(posedge clk) begin
    if (rst) cnt <= 0;
    else     cnt <= cnt + 1;
  end

  typedef struct {
    string       name;
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endfunction

  // Scoreboard monitor: a response is handed over when valid and ready are
  // both high at the next rising edge; sample it mid-cycle.
  always @(negedge clk) begin
    if (!rst && m_valid && resp_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: got rdata 0x%h err %0b, expected no response",
                 m_rdata, m_err);
      end else begin
        mon_e = sb_q.pop_front();
        $display("txn %s: rdata=0x%h err=%0b (expected 0x%h err=%0b)",
                 mon_e.name, m_rdata, m_err, mon_e.rdata, mon_e.err);
        chk({mon_e.name, "_rdata"}, m_rdata, mon_e.rdata);
        chk({mon_e.name, "_err"}, 64'(m_err), 64'(mon_e.err));
      end
    end
  end

  task automatic wait_cyc(input int x);
    while (cnt < x) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input string name, input logic [63:0] rdata,
                          input logic err);
    exp_t e;
    e.name  = name;
    e.rdata = rdata;
    e.err   = err;
    sb_q.push_back(e);
  endtask

  // Presents one request to an idle DUT; returns #1 after the accept edge.
  task automatic issue(input logic s, input logic wen, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [7:0] mask,
                       input string name, input logic [63:0] exp_rdata,
                       input logic exp_err);
    push_exp(name, exp_rdata, exp_err);
    sel       = s;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = mask;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (sb_q.size() != 0 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL resp_timeout: got no response for %s within 50 cycles, expected one",
               sb_q[0].name);
      sb_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running at time limit, expected completion");
    $fatal(1, "watchdog");
  end

  int a_cyc;

  initial begin
    rst        = 1'b1;
    sel        = 1'b0;
    req_valid  = 1'b0;
    req_wen    = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_wmask  = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, both instances.
    @(negedge clk);
    chk("rst_req_ready_1",  64'(req_ready_a),  64'd1);
    chk("rst_req_ready_4",  64'(req_ready_b),  64'd1);
    chk("rst_resp_valid_1", 64'(resp_valid_a), 64'd0);
    chk("rst_resp_valid_4", 64'(resp_valid_b), 64'd0);
    chk("rst_resp_rdata",   resp_rdata_a,      64'd0);
    chk("rst_resp_err",     64'(resp_err_a),   64'd0);
    chk("rst_mtip",         64'(mtip_a),       64'd0);
    chk("rst_msip",         64'(msip_a),       64'd0);

    // mtimecmp=20 written while mtime=5 (dut1).
    wait_cyc(5);
    issue(1'b0, 1'b1, A_CMP, 64'd20, 8'hFF, "wr_cmp20", 64'd0, 1'b0);
    wait_idle();

    // mtime equals elapsed cycles at the accept cycle.
    wait_cyc(10);
    issue(1'b0, 1'b0, A_TIME, 64'd0, 8'h00, "rd_mtime_div1", 64'd10, 1'b0);
    wait_idle();

    // mtime is 20 during cycle 20, so mtip goes high in cycle 21.
    wait_cyc(20);
    @(negedge clk);
    chk("mtip_before_match", 64'(mtip_a), 64'd0);
    wait_cyc(21);
    @(negedge clk);
    chk("mtip_rise", 64'(mtip_a), 64'd1);

    // mtimecmp back to all-ones: mtip still high at A+1, low at A+2.
    wait_cyc(25);
    issue(1'b0, 1'b1, A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, "wr_cmp_ones", 64'd0, 1'b0);
    @(negedge clk);
    chk("mtip_hold", 64'(mtip_a), 64'd1);
    wait_idle();
    @(negedge clk);
    chk("mtip_fall", 64'(mtip_a), 64'd0);

    // TICK_DIV=4: 40 cycles after reset mtime is 10.
    wait_cyc(40);
    issue(1'b1, 1'b0, A_TIME, 64'd0, 8'h00, "rd_mtime_div4", 64'd10, 1'b0);
    wait_idle();

    // Wrap: near-max value plus the two ticks of the next 8 cycles gives 0.
    a_cyc = cnt;
    issue(1'b1, 1'b1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, "wr_mtime_near_max",
          64'd0, 1'b0);
    wait_idle();
    wait_cyc(a_cyc + 9);
    issue(1'b1, 1'b0, A_TIME, 64'd0, 8'h00, "rd_mtime_wrap", 64'd0, 1'b0);
    wait_idle();

    // Write on a tick cycle: the written value wins, the tick is lost, and
    // the next tick is still 4 cycles later.
    while (cnt % 4 != 3) begin
      @(posedge clk);
      #1;
    end
    issue(1'b1, 1'b1, A_TIME, 64'd100, 8'hFF, "wr_mtime_on_tick", 64'd0, 1'b0);
    wait_idle();
    issue(1'b1, 1'b0, A_TIME, 64'd0, 8'h00, "rd_mtime_after_tick_wr", 64'd100, 1'b0);
    wait_idle();

    // msip: only bit 0 is writable and only under its byte enable.
    issue(1'b0, 1'b1, A_MSIP, 64'hFF, 8'h01, "wr_msip_ff", 64'd0, 1'b0);
    @(negedge clk);
    chk("msip_set", 64'(msip_a), 64'd1);
    wait_idle();
    issue(1'b0, 1'b0, A_MSIP, 64'd0, 8'h00, "rd_msip_1", 64'd1, 1'b0);
    wait_idle();
    issue(1'b0, 1'b1, A_MSIP, 64'd0, 8'h00, "wr_msip_nomask", 64'd0, 1'b0);
    wait_idle();
    issue(1'b0, 1'b0, A_MSIP, 64'd0, 8'h00, "rd_msip_still_1", 64'd1, 1'b0);
    wait_idle();
    issue(1'b0, 1'b1, A_MSIP, 64'd0, 8'h01, "wr_msip_0", 64'd0, 1'b0);
    @(negedge clk);
    chk("msip_clear", 64'(msip_a), 64'd0);
    wait_idle();

    // Partial mtimecmp write over all-ones.
    issue(1'b0, 1'b1, A_CMP, 64'h1122_3344_5566_7788, 8'h0F, "wr_cmp_lo", 64'd0, 1'b0);
    wait_idle();
    issue(1'b0, 1'b0, A_CMP, 64'd0, 8'h00, "rd_cmp_lo", 64'hFFFF_FFFF_5566_7788, 1'b0);
    wait_idle();

    // Unmapped and misaligned accesses fault without changing state.
    issue(1'b0, 1'b0, BASE + 64'h8, 64'd0, 8'h00, "rd_err_08", 64'd0, 1'b1);
    wait_idle();
    issue(1'b0, 1'b0, BASE + 64'h4004, 64'd0, 8'h00, "rd_err_4004", 64'd0, 1'b1);
    wait_idle();
    issue(1'b0, 1'b1, BASE + 64'h4004, 64'd0, 8'hFF, "wr_err_4004", 64'd0, 1'b1);
    wait_idle();
    issue(1'b0, 1'b0, A_CMP, 64'd0, 8'h00, "rd_cmp_unchanged", 64'hFFFF_FFFF_5566_7788, 1'b0);
    wait_idle();

    // Stalled response: held stable, no second accept until after handshake.
    resp_ready = 1'b0;
    issue(1'b0, 1'b0, BASE + 64'h8, 64'd0, 8'h00, "rd_err_stall", 64'd0, 1'b1);
    push_exp("rd_cmp_after_stall", 64'hFFFF_FFFF_5566_7788, 1'b0);
    req_addr  = A_CMP;
    req_wen   = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_resp_valid", 64'(resp_valid_a), 64'd1);
      chk("stall_resp_err",   64'(resp_err_a),   64'd1);
      chk("stall_resp_rdata", resp_rdata_a,      64'd0);
      chk("stall_req_ready",  64'(req_ready_a),  64'd0);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post_handshake_resp_valid", 64'(resp_valid_a), 64'd0);
    chk("post_handshake_req_ready",  64'(req_ready_a),  64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_idle();

    // Reset in the middle of a transaction drops the pending response.
    issue(1'b0, 1'b1, A_MSIP, 64'd1, 8'h01, "wr_msip_pre_rst", 64'd0, 1'b0);
    wait_idle();
    resp_ready = 1'b0;
    issue(1'b0, 1'b0, A_TIME, 64'd0, 8'h00, "rd_dropped", 64'd0, 1'b0);
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1;
    rst        = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("midrst_resp_valid", 64'(resp_valid_a), 64'd0);
    chk("midrst_req_ready",  64'(req_ready_a),  64'd1);
    chk("midrst_resp_rdata", resp_rdata_a,      64'd0);
    chk("midrst_msip",       64'(msip_a),       64'd0);
    chk("midrst_mtip",       64'(mtip_a),       64'd0);
    issue(1'b0, 1'b0, A_TIME, 64'd0, 8'h00, "rd_mtime_post_rst", 64'd0, 1'b0);
    wait_idle();
    issue(1'b0, 1'b0, A_CMP, 64'd0, 8'h00, "rd_cmp_post_rst", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    wait_idle();

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
